// File: rtl/inter_msg_arbiter.sv
// Round-robin arbiter sharing one interboard message transmitter between NUM_REQ
// game-control handlers; buffers one request per handler and tracks the inter_ready handshake.
module inter_msg_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  interboard_rst,
    input  logic [NUM_REQ-1:0]    req_en,
    input  logic [22*NUM_REQ-1:0] req_msg,
    input  logic                  inter_ready,
    output logic [NUM_REQ-1:0]    req_busy,
    output logic [NUM_REQ-1:0]    req_done,
    output logic [NUM_REQ-1:0]    req_err,
    output logic                  ctrl_en,
    output logic                  ctrl_move_dir,
    output logic [4:0]            ctrl_block_x,
    output logic [2:0]            ctrl_block_y,
    output logic [3:0]            ctrl_msg_type,
    output logic [5:0]            ctrl_card,
    output logic [2:0]            ctrl_sel_len
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        DONE
    } state_t;

    state_t             state;
    logic [NUM_REQ-1:0] pending;
    logic [21:0]        msg_buf [NUM_REQ];
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      grant;
    logic [PW-1:0]      pick;
    logic               pick_valid;
    logic [PW-1:0]      rr_next;
    logic [CW-1:0]      cnt;
    logic [21:0]        ctrl_msg;

    // First pending requester at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!pick_valid && pending[PW'(idx)]) begin
                pick       = PW'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    assign rr_next = (grant == PW'(NUM_REQ - 1)) ? '0 : grant + PW'(1);

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_en[i] && !pending[i]) begin
                msg_buf[i] <= req_msg[22*i +: 22];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            rr_ptr   <= '0;
            grant    <= '0;
            cnt      <= '0;
            ctrl_en  <= 1'b0;
            ctrl_msg <= '0;
            req_done <= '0;
            req_err  <= '0;
        end else if (interboard_rst) begin
            state    <= IDLE;
            pending  <= '0;
            rr_ptr   <= '0;
            grant    <= '0;
            cnt      <= '0;
            ctrl_en  <= 1'b0;
            ctrl_msg <= '0;
            req_done <= '0;
            req_err  <= '0;
        end else begin
            ctrl_en  <= 1'b0;
            req_done <= '0;
            req_err  <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_en[i] && !pending[i]) begin
                    pending[i] <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (pick_valid && inter_ready) begin
                        grant    <= pick;
                        ctrl_msg <= msg_buf[pick];
                        ctrl_en  <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!inter_ready) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                        req_done[grant] <= 1'b1;
                        req_err[grant]  <= 1'b1;
                        state           <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (inter_ready) begin
                        req_done[grant] <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    // Buffer stays busy through DONE so a same-cycle re-request is dropped.
                    pending[grant] <= 1'b0;
                    rr_ptr         <= rr_next;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_busy = pending;
    assign {ctrl_move_dir, ctrl_block_x, ctrl_block_y,
            ctrl_msg_type, ctrl_card, ctrl_sel_len} = ctrl_msg;

endmodule

// File: tb/tb_inter_msg_arbiter.sv
// Bench for inter_msg_arbiter: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inter_msg_arbiter;

    localparam int NR  = 4;
    localparam int ACK = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              interboard_rst;
    logic [NR-1:0]     req_en;
    logic [22*NR-1:0]  req_msg;
    logic              inter_ready;
    logic [NR-1:0]     req_busy, req_done, req_err;
    logic              ctrl_en, ctrl_move_dir;
    logic [4:0]        ctrl_block_x;
    logic [2:0]        ctrl_block_y;
    logic [3:0]        ctrl_msg_type;
    logic [5:0]        ctrl_card;
    logic [2:0]        ctrl_sel_len;

    inter_msg_arbiter #(.NUM_REQ(NR), .ACK_TIMEOUT(ACK)) dut (
        .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
        .req_en(req_en), .req_msg(req_msg), .inter_ready(inter_ready),
        .req_busy(req_busy), .req_done(req_done), .req_err(req_err),
        .ctrl_en(ctrl_en), .ctrl_move_dir(ctrl_move_dir),
        .ctrl_block_x(ctrl_block_x), .ctrl_block_y(ctrl_block_y),
        .ctrl_msg_type(ctrl_msg_type), .ctrl_card(ctrl_card),
        .ctrl_sel_len(ctrl_sel_len)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: request buffers plus timestamps of the transfer in flight.
    bit   [NR-1:0] m_pend = '0;
    logic [21:0]   m_buf [NR];
    int            m_rr = 0, m_g = 0, m_issue = 0, m_done = -1, m_cyc = 0;
    bit            m_active = 0, m_low = 0;
    logic [NR-1:0] e_done = '0, e_err = '0;
    logic          e_en = 1'b0;
    logic [21:0]   e_ctrl = '0;

    int            last_en_cyc = 0, done_cyc = 0, done_idx = -1;
    logic [21:0]   last_ctrl = '0;

    function automatic logic [21:0] pack(input int dir, x, y, t, card, sel);
        return {1'(dir), 5'(x), 3'(y), 4'(t), 6'(card), 3'(sel)};
    endfunction

    function automatic logic [34:0] outs();
        return {req_busy, req_done, req_err, ctrl_en, ctrl_move_dir, ctrl_block_x,
                ctrl_block_y, ctrl_msg_type, ctrl_card, ctrl_sel_len};
    endfunction

    task automatic check_lit(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit [NR-1:0] old;
        m_cyc++;
        if (rst || interboard_rst) begin
            m_pend = '0; m_rr = 0; m_active = 0;
            e_done = '0; e_err = '0; e_en = 1'b0; e_ctrl = '0;
            return;
        end
        old    = m_pend;
        e_done = '0; e_err = '0; e_en = 1'b0;
        if (m_active) begin
            if (m_done >= 0) begin
                m_pend[m_g] = 1'b0;
                m_rr        = (m_g + 1) % NR;
                m_active    = 0;
            end else if (m_cyc >= m_issue + 2) begin
                if (!m_low) begin
                    if (!inter_ready) m_low = 1;
                    else if (m_cyc - m_issue == ACK + 1) begin
                        m_done = m_cyc; e_done[m_g] = 1'b1; e_err[m_g] = 1'b1;
                    end
                end else if (inter_ready) begin
                    m_done = m_cyc; e_done[m_g] = 1'b1;
                end
            end
        end else if (inter_ready && old != 0) begin
            for (int k = 0; k < NR; k++) begin
                int idx = (m_rr + k) % NR;
                if (old[idx]) begin
                    m_g = idx;
                    break;
                end
            end
            m_active = 1; m_issue = m_cyc; m_low = 0; m_done = -1;
            e_en = 1'b1; e_ctrl = m_buf[m_g];
        end
        for (int i = 0; i < NR; i++) begin
            if (!old[i] && req_en[i]) begin
                m_pend[i] = 1'b1;
                m_buf[i]  = req_msg[22*i +: 22];
            end
        end
    endtask

    task automatic cycle();
        logic [34:0] exp;
        @(negedge clk);
        model_step();
        exp = {m_pend, e_done, e_err, e_en, e_ctrl};
        compared++;
        if (outs() !== exp) begin
            mismatched++;
            $display("FAIL cycle %0d outputs: got %h, expected %h", m_cyc, outs(), exp);
        end
        if (ctrl_en) begin
            last_en_cyc = m_cyc;
            last_ctrl   = {ctrl_move_dir, ctrl_block_x, ctrl_block_y,
                           ctrl_msg_type, ctrl_card, ctrl_sel_len};
        end
        if (req_done != 0) begin
            done_cyc = m_cyc;
            for (int i = 0; i < NR; i++) if (req_done[i]) done_idx = i;
        end
    endtask

    task automatic wait_en(input int max);
        int n = 0;
        while (!ctrl_en && n < max) begin cycle(); n++; end
        if (!ctrl_en) check_lit("wait_ctrl_en_timeout", 0, 1);
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (req_done == 0 && n < max) begin cycle(); n++; end
        if (req_done == 0) check_lit("wait_req_done_timeout", 0, 1);
    endtask

    // Acts as the transmitter: busy for 'low' cycles after the strobe.
    task automatic serve(input int low, output int who);
        done_idx = -1;
        wait_en(40);
        inter_ready = 1'b0;
        repeat (low) cycle();
        inter_ready = 1'b1;
        wait_done(20);
        who = done_idx;
    endtask

    initial begin
        int who, n_en, n_done, t_en;
        int ord2[3] = '{0, 1, 3};
        int ord3[4] = '{0, 2, 0, 2};
        logic [21:0] msg_a, msg_b;

        rst = 1'b1; interboard_rst = 1'b0; inter_ready = 1'b1;
        req_en = '0; req_msg = '0;
        repeat (2) cycle();
        check_lit("reset_outputs", longint'(outs()), 0);
        rst = 1'b0;
        cycle();

        // Single request
        req_msg[21:0] = pack(1, 3, 2, 6, 17, 3);
        req_en = 4'b0001;
        cycle();
        check_lit("t1_busy_at_capture", req_busy, 1);
        req_en = '0;
        cycle();
        check_lit("t1_ctrl_en", ctrl_en, 1);
        check_lit("t1_move_dir", ctrl_move_dir, 1);
        check_lit("t1_block_x", ctrl_block_x, 3);
        check_lit("t1_block_y", ctrl_block_y, 2);
        check_lit("t1_msg_type", ctrl_msg_type, 6);
        check_lit("t1_card", ctrl_card, 17);
        check_lit("t1_sel_len", ctrl_sel_len, 3);
        inter_ready = 1'b0;
        cycle();
        check_lit("t1_ctrl_en_one_cycle", ctrl_en, 0);
        repeat (2) cycle();
        check_lit("t1_no_early_done", req_done, 0);
        inter_ready = 1'b1;
        cycle();
        check_lit("t1_done", req_done, 1);
        check_lit("t1_no_err", req_err, 0);
        cycle();
        check_lit("t1_busy_clear", req_busy, 0);

        // Simultaneous requests from rr_ptr 0
        interboard_rst = 1'b1;
        cycle();
        interboard_rst = 1'b0;
        req_msg = {$urandom, $urandom, $urandom};
        req_en = 4'b1011;
        cycle();
        req_en = '0;
        for (int k = 0; k < 3; k++) begin
            serve(2, who);
            check_lit($sformatf("t2_grant%0d", k), who, ord2[k]);
        end

        // Fairness with a re-requesting handler
        req_en = 4'b0101;
        cycle();
        req_en = '0;
        for (int k = 0; k < 4; k++) begin
            serve(2, who);
            check_lit($sformatf("t3_grant%0d", k), who, ord3[k]);
            cycle();
            if (k < 2 && who >= 0) begin
                req_en = NR'(1 << who);
                cycle();
                req_en = '0;
            end
        end

        // Drop while busy and in the DONE cycle
        msg_a = pack(0, 21, 5, 9, 42, 1);
        msg_b = pack(1, 7, 1, 2, 3, 6);
        req_msg[22 +: 22] = msg_a;
        req_en = 4'b0010;
        cycle();
        req_msg[22 +: 22] = msg_b;
        cycle();
        req_en = '0;
        wait_en(10);
        check_lit("t4_first_msg_kept", longint'(last_ctrl), longint'(msg_a));
        inter_ready = 1'b0;
        repeat (2) cycle();
        inter_ready = 1'b1;
        done_idx = -1;
        wait_done(10);
        check_lit("t4_done_idx", done_idx, 1);
        req_msg[22 +: 22] = msg_b;
        req_en = 4'b0010;
        cycle();
        req_en = '0;
        n_en = 0;
        repeat (15) begin cycle(); if (ctrl_en) n_en++; end
        check_lit("t4_no_extra_issue", n_en, 0);

        // Timeout with inter_ready stuck high
        inter_ready = 1'b1;
        req_en = 4'b0011;
        cycle();
        req_en = '0;
        wait_en(10);
        t_en = last_en_cyc;
        done_idx = -1;
        wait_done(20);
        check_lit("t5_timeout_latency", done_cyc - t_en, 9);
        check_lit("t5_done_idx", done_idx, 0);
        check_lit("t5_err", req_err, 1);
        serve(3, who);
        check_lit("t5_next_served", who, 1);

        // interboard_rst during WAIT_DONE
        req_en = 4'b0100;
        cycle();
        req_en = '0;
        wait_en(10);
        inter_ready = 1'b0;
        repeat (2) cycle();
        interboard_rst = 1'b1;
        cycle();
        check_lit("t6_outputs_cleared", longint'(outs()), 0);
        interboard_rst = 1'b0;
        inter_ready = 1'b1;
        n_done = 0;
        repeat (5) begin cycle(); if (req_done != 0) n_done++; end
        check_lit("t6_no_done_after_abort", n_done, 0);
        req_en = 4'b0001;
        cycle();
        req_en = '0;
        serve(3, who);
        check_lit("t6_serviced_after_reset", who, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NR; i++) req_en[i] = ($urandom_range(0, 5) == 0);
            req_msg = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) inter_ready = ~inter_ready;
            interboard_rst = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0; interboard_rst = 1'b0; req_en = '0; inter_ready = 1'b1;
        repeat (20) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/inter_msg_arbiter.md
# inter_msg_arbiter

Shares the single interboard message transmitter between up to NUM_REQ game-control handlers (shift, draw, play, turn-end), each of which emits one-cycle `*_ctrl_en` message requests. The block buffers one request per requester, picks a winner round-robin, drives the transmitter's ctrl bus with a one-cycle enable, and tracks the `inter_ready` handshake to completion. It sits between the handle_* blocks and the interboard communication module.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- ACK_TIMEOUT, 1023: cycles allowed for `inter_ready` to fall after issue (≥2).

- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- interboard_rst  in  1  synchronous clear, same effect as rst
- req_en  in  NUM_REQ  one-cycle request pulse per requester
- req_msg  in  22*NUM_REQ  requester i at [22*i +: 22], packed {move_dir[21], block_x[20:16], block_y[15:13], msg_type[12:9], card[8:3], sel_len[2:0]}
- inter_ready  in  1  transmitter idle (1) / busy (0)
- req_busy  out  NUM_REQ  requester i has pending or in-flight message
- req_done  out  NUM_REQ  one-cycle pulse: requester i's message finished
- req_err  out  NUM_REQ  one-cycle pulse with req_done: finished by timeout
- ctrl_en  out  1  one-cycle send strobe to transmitter
- ctrl_move_dir  out  1
- ctrl_block_x  out  5
- ctrl_block_y  out  3
- ctrl_msg_type  out  4
- ctrl_card  out  6
- ctrl_sel_len  out  3

## Operation
- Per requester: 1-deep buffer (22-bit msg + pending flag). req_en[i] with buffer free → capture req_msg slice, set pending. req_en[i] while pending/in-flight → dropped, no state change.
- Requests from several requesters in same cycle all captured.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DONE.
  - IDLE: any pending and inter_ready=1 → grant = first pending index at or after rr_ptr (wrapping), load ctrl_* registers from its buffer, → ISSUE. Otherwise stay.
  - ISSUE: ctrl_en=1 for exactly this cycle; clear timeout counter; → WAIT_ACK.
  - WAIT_ACK: inter_ready=0 → WAIT_DONE; else counter increments; counter = ACK_TIMEOUT-1 → DONE with err flag.
  - WAIT_DONE: inter_ready=1 → DONE. No timeout.
  - DONE: req_done[grant]=1 (req_err[grant]=err flag); clear pending[grant]; rr_ptr = grant+1 mod NUM_REQ; → IDLE.
- ctrl_* data outputs held stable from ISSUE through DONE; keep last value in IDLE.
- req_busy[i] = pending[i] (includes in-flight); drops cycle after req_done[i].
- req_en[i] in the DONE cycle for grant i: dropped (buffer still busy).
- Reset (rst or interboard_rst) mid-transfer: abort, no req_done; all buffers cleared.

## Timing
- Reset values: all outputs 0, rr_ptr=0, FSM IDLE, buffers empty.
- All outputs registered.
- req_en sampled at edge E0 with FSM idle and inter_ready=1: ISSUE entered at E1, ctrl_en high E1–E2; req_busy high from E0.
- Minimum service: 4 cycles from ISSUE to DONE exit with 1-cycle transmitter busy; back-to-back grants separated by ≥1 IDLE cycle.
- Timeout: req_done/req_err asserted ACK_TIMEOUT+1 cycles after ISSUE.
- rr_ptr arithmetic wraps at NUM_REQ (non-power-of-two supported).

## Test plan
- Single request: req_en[0] with msg {1,5'd3,3'd2,4'd6,6'd17,3'd3}, inter_ready held 1 then low 3 cycles → ctrl_en one cycle, ctrl_* match fields, req_done[0] one cycle after inter_ready returns 1, req_busy[0] clears next cycle.
- Simultaneous req_en=4'b1011, rr_ptr=0 → grants in order 0,1,3; each ctrl_en only after previous req_done.
- Fairness: requester 0 re-requests right after each done, requester 2 pending → grants alternate 0,2,0,2.
- Drop: req_en[1] twice while busy → exactly one ctrl_en/req_done for requester 1, msg from first request.
- Timeout (ACK_TIMEOUT=8): inter_ready stuck 1 → req_done[0] and req_err[0] 9 cycles after ctrl_en, then next pending served.
- interboard_rst asserted in WAIT_DONE → all outputs 0, no req_done, next req_en serviced normally.
